// File: rtl/rlgl_pkg.sv
// Shared state encodings and constants for the red-light/green-light phase controller.
package rlgl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_GREEN = 3'd1;
  localparam state_t ST_RED   = 3'd2;
  localparam state_t ST_OVER  = 3'd3;
  localparam state_t ST_WIN   = 3'd4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          PHASE_W   = 8;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/light_phase_ctrl_tick_gen.sv
// Tick divider: one-cycle strobe every DIV clocks, restarted by clr.
module tick_gen #(
  parameter int DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/light_phase_ctrl.sv
// Red-light/green-light game FSM: alternating phases, strike detection, lives and win/over.
// Define RAND_PHASE_EN to stretch each red phase by 0..3 ticks drawn from an LFSR.
module light_phase_ctrl
  import rlgl_pkg::*;
#(
  parameter int TICK_DIV    = 12500000,
  parameter int GREEN_TICKS = 8,
  parameter int RED_TICKS   = 6,
  parameter int GRACE_TICKS = 1,
  parameter int LIVES       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move,
  input  logic       finish,
  output logic       green,
  output logic       red,
  output logic [1:0] lives,
  output logic       hit,
  output logic       game_over,
  output logic       win,
  output logic [2:0] state
);

  localparam logic [PHASE_W-1:0] GREEN_LAST = PHASE_W'(GREEN_TICKS - 1);
  localparam logic [PHASE_W-1:0] GRACE      = PHASE_W'(GRACE_TICKS);
  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

  state_t             state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic               hit_q, hit_d;
  logic               struck_q, struck_d;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] red_last;
  logic               tick;
  logic               phase_entry;
  logic               red_end;

  // Any state change starts a fresh phase, so the divider realigns to it.
  assign phase_entry = (state_d != state_q);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (phase_entry),
    .tick  (tick)
  );

`ifdef RAND_PHASE_EN
  logic [15:0]        lfsr_q;
  logic [PHASE_W-1:0] red_last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q     <= LFSR_SEED;
      red_last_q <= PHASE_W'(RED_TICKS - 1);
    end else begin
      lfsr_q <= lfsrStep(lfsr_q);
      if (state_d == ST_RED && state_q != ST_RED)
        red_last_q <= PHASE_W'(RED_TICKS - 1) + PHASE_W'(lfsr_q[1:0]);
    end
  end

  assign red_last = red_last_q;
`else
  assign red_last = PHASE_W'(RED_TICKS - 1);
`endif

  assign red_end = tick && (phase_q == red_last);

  // A strike always beats finish; finish only wins once this phase's strike is spent.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    hit_d    = 1'b0;
    struck_d = struck_q;
    case (state_q)
      ST_GREEN: begin
        struck_d = 1'b0;
        if (finish)                              state_d = ST_WIN;
        else if (tick && phase_q == GREEN_LAST)  state_d = ST_RED;
      end
      ST_RED: begin
        if (phase_q < GRACE) begin
          if (finish)       state_d = ST_WIN;
          else if (red_end) state_d = ST_GREEN;
        end else if ((move || finish) && !struck_q) begin
          hit_d    = 1'b1;
          struck_d = 1'b1;
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = ST_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            if (red_end) state_d = ST_GREEN;
          end
        end else if (finish) begin
          state_d = ST_WIN;
        end else if (red_end) begin
          state_d = ST_GREEN;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_GREEN;
          lives_d = LIVES_INIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lives_q  <= LIVES_INIT;
      hit_q    <= 1'b0;
      struck_q <= 1'b0;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      hit_q    <= hit_d;
      struck_q <= struck_d;
      if (phase_entry)
        phase_q <= '0;
      else if (tick && (state_q == ST_GREEN || state_q == ST_RED))
        phase_q <= phase_q + 1'b1;
    end
  end

  assign state     = state_q;
  assign lives     = lives_q;
  assign hit       = hit_q;
  assign green     = (state_q == ST_GREEN) || (state_q == ST_WIN);
  assign red       = (state_q == ST_RED);
  assign game_over = (state_q == ST_OVER);
  assign win       = (state_q == ST_WIN);

endmodule

// File: doc/light_phase_ctrl.md
LIGHT_PHASE_CTRL -- requirements
Module: light_phase_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12500000: clk cycles per game tick.
REQ-002 SHALL have parameter GREEN_TICKS, default 8: ticks per green phase.
REQ-003 SHALL have parameter RED_TICKS, default 6: ticks per red phase.
REQ-004 SHALL have parameter GRACE_TICKS, default 1: ticks at red start during which movement is ignored; legal range 0 to RED_TICKS-1.
REQ-005 SHALL have parameter LIVES, default 3: starting lives, 1..3.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have ports start, move and finish, inputs, 1 bit each: start begins a game, move is player motion (level), finish is the player crossing the line (level).
REQ-009 SHALL have ports green and red, outputs, 1 bit each: light indication, one-hot while playing.
REQ-010 SHALL have port lives, output, 2 bits: remaining lives.
REQ-011 SHALL have ports hit, game_over and win, outputs, 1 bit each: hit is a one-cycle strike pulse, game_over and win are level flags.
REQ-012 SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-013 SHALL implement states IDLE=0, GREEN=1, RED=2, OVER=3, WIN=4.
REQ-014 IDLE: outputs green=0 and red=0; start=1 loads lives=LIVES, clears the phase counter, and enters GREEN on the next clk.
REQ-015 SHALL count ticks: one-cycle tick strobe every TICK_DIV clk cycles; the divider is cleared on every phase entry.
REQ-016 GREEN: green=1; move is ignored; after GREEN_TICKS ticks, enter RED on the cycle after the final tick.
REQ-017 RED: red=1; after RED_TICKS ticks, enter GREEN.
REQ-018 RED active window: move=1 on any cycle after GRACE_TICKS ticks of the red phase counts as a strike, at most one strike per red phase.
REQ-019 Strike effects: hit=1 for exactly one cycle; lives decrements by 1 on the same edge; the FSM stays in RED.
REQ-020 Strike when lives=1: lives becomes 0 and the FSM enters OVER on the same edge.
REQ-021 finish=1 in GREEN or in the RED grace window SHALL enter WIN next cycle.
REQ-022 finish=1 in the RED active window SHALL be treated as move.
REQ-023 finish and move in the same active-window cycle: strike wins; WIN is taken only if lives remain and finish is still high after the strike cycle.
REQ-024 Phase-end tick coincident with a strike: the strike is applied and the phase still ends, unless the strike causes OVER.
REQ-025 OVER: game_over=1 and lights off. WIN: win=1 and green=1. In both states, start=1 SHALL restart as in REQ-014.
REQ-026 lives SHALL never wrap below 0.

Reset
REQ-027 reset=0 SHALL asynchronously force: state=IDLE, lives=LIVES, hit=0, game_over=0, win=0, green=0, red=0, and counters=0.
REQ-028 Reset during play SHALL abort the game with no hit pulse; operation resumes in IDLE on the first clk after release.

Configuration
REQ-029 With RAND_PHASE_EN defined, each RED phase length SHALL be RED_TICKS + r, where r is 0..3 taken from a 16-bit LFSR (seed 16'hACE1 on reset, polynomial x^16+x^14+x^13+x^11+1) that steps every clk; r is sampled at RED entry.
REQ-030 Without RAND_PHASE_EN, RED length SHALL be exactly RED_TICKS and no LFSR logic SHALL exist.

Structure
REQ-031 A shared package rlgl_pkg SHALL hold the state typedef/encodings and the LFSR seed constant.
REQ-032 The tick divider SHALL be a sub-module tick_gen, with parameter DIV and ports clk, reset, clr, tick.

Verification (TICK_DIV=4, GREEN_TICKS=3, RED_TICKS=2, GRACE_TICKS=1, LIVES=3, RAND_PHASE_EN off)
REQ-033 Start pulse, no move -> green for 12 clk, red for 8 clk, repeating; lives stays 3; hit never asserts.
REQ-034 move held through the whole first red phase -> exactly one hit pulse, 5 clk after red entry; lives=2.
REQ-035 move only during red grace (clk 0-3 of red) -> no hit; lives=3.
REQ-036 Three red phases, each with a strike -> lives goes 3 to 2 to 1 to 0; OVER entered on the third strike edge; game_over=1; start then restarts with lives=3.
REQ-037 finish during GREEN -> win=1 next clk; finish with move in the red active window -> hit pulse, no win that cycle.
REQ-038 reset=0 asserted mid-RED with lives=1 -> all outputs at reset values immediately, without waiting for clk.
